// File: rtl/sdram_pkg.sv
`timescale 1ns/1ps
// Shared SDRAM controller definitions: command encodings, FSM states,
// device timing constants and the mode-register helper.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_REF,
    INIT_MRS,
    IDLE,
    ACTIVATE,
    RW,
    READ_WAIT,
    RECOVER,
    REFRESH
  } sdram_state_e;

  localparam int tRCD = 2;
  localparam int tRP  = 2;
  localparam int tRFC = 7;
  localparam int tMRD = 2;
  localparam int tWR  = 2;

  // Burst length 1, sequential, burst writes; only the CAS field varies.
  function automatic logic [12:0] mode_word(input int cas_latency);
    return (cas_latency == 3) ? 13'h030 : 13'h020;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
`timescale 1ns/1ps
// Free-running auto-refresh interval counter; raises refresh_pending every
// REFRESH_INTERVAL enabled cycles and holds it until the controller clears it.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic refresh_pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          expire;

  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == CW'(REFRESH_INTERVAL - 1)) begin
      count_d = '0;
      expire  = 1'b1;
    end else begin
      count_d = count_q + 1'b1;
    end
    pending_d = expire | (pending_q & ~clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign refresh_pending = pending_q;

endmodule

// File: rtl/avalon_sdram_controller.sv
`timescale 1ns/1ps
// Single-word Avalon-MM to SDR SDRAM controller: power-up init, one access at a
// time with auto-precharge, and periodic auto-refresh. All SDRAM pins are registered.
module avalon_sdram_controller
  import sdram_pkg::*;
#(
  parameter int CAS_LATENCY      = 2,
  parameter int INIT_CYCLES      = 10000,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [24:0] avs_address,
  input  logic [1:0]  avs_byteenable,
  input  logic [15:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic        avs_readdatavalid,
  output logic [15:0] avs_readdata,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  output logic        sdram_cke,
  input  logic [15:0] sdram_dq_read,
  output logic [15:0] sdram_dq_write,
  output logic        sdram_dq_en
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 64);

  sdram_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        ref_idx_q, ref_idx_d;
  logic        is_write_q, is_write_d;
  logic [24:0] req_addr_q, req_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;

  sdram_cmd_e  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic [1:0]  dqm_q, dqm_d;
  logic [15:0] dq_write_q, dq_write_d;
  logic        dq_en_q, dq_en_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic refresh_pending;
  logic refresh_clear;
  logic timer_en;
  logic accept;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk            (clk),
    .reset          (reset),
    .enable         (timer_en),
    .clear          (refresh_clear),
    .refresh_pending(refresh_pending)
  );

  assign avs_waitrequest = reset | (state_q != IDLE) | refresh_pending;
  assign accept          = (avs_read | avs_write) & ~avs_waitrequest;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ref_idx_d     = ref_idx_q;
    is_write_d    = is_write_q;
    req_addr_d    = req_addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    cmd_d         = CMD_NOP;
    addr_d        = addr_q;
    ba_d          = ba_q;
    dqm_d         = 2'b11;
    dq_write_d    = dq_write_q;
    dq_en_d       = 1'b0;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    refresh_clear = 1'b0;
    timer_en      = 1'b1;

    case (state_q)
      INIT_WAIT: begin
        timer_en = 1'b0;
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          cmd_d   = CMD_PRE;
          addr_d  = 13'h0400;
          cnt_d   = CNT_W'(tRP - 1);
          state_d = INIT_PRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT_PRE: begin
        timer_en = 1'b0;
        if (cnt_q == '0) begin
          cmd_d     = CMD_REF;
          cnt_d     = CNT_W'(tRFC - 1);
          ref_idx_d = 1'b0;
          state_d   = INIT_REF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      INIT_REF: begin
        timer_en = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!ref_idx_q) begin
          cmd_d     = CMD_REF;
          cnt_d     = CNT_W'(tRFC - 1);
          ref_idx_d = 1'b1;
        end else begin
          cmd_d   = CMD_MRS;
          addr_d  = mode_word(CAS_LATENCY);
          ba_d    = 2'b00;
          cnt_d   = CNT_W'(tMRD - 1);
          state_d = INIT_MRS;
        end
      end
      INIT_MRS: begin
        timer_en = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      IDLE: begin
        // Refresh always wins over a new request; waitrequest is already high.
        if (refresh_pending) begin
          cmd_d         = CMD_REF;
          refresh_clear = 1'b1;
          cnt_d         = CNT_W'(tRFC - 1);
          state_d       = REFRESH;
        end else if (accept) begin
          cmd_d      = CMD_ACT;
          addr_d     = avs_address[22:10];
          ba_d       = avs_address[24:23];
          is_write_d = avs_write;
          req_addr_d = avs_address;
          wdata_d    = avs_writedata;
          be_d       = avs_byteenable;
          cnt_d      = CNT_W'(tRCD - 2);
          state_d    = ACTIVATE;
        end
      end
      ACTIVATE: begin
        if (cnt_q == '0) state_d = RW;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RW: begin
        addr_d = {2'b00, 1'b1, req_addr_q[9:0]};
        ba_d   = req_addr_q[24:23];
        if (is_write_q) begin
          cmd_d      = CMD_WR;
          dq_en_d    = 1'b1;
          dq_write_d = wdata_q;
          dqm_d      = ~be_q;
          cnt_d      = CNT_W'(tWR + tRP - 1);
          state_d    = RECOVER;
        end else begin
          cmd_d   = CMD_RD;
          dqm_d   = 2'b00;
          cnt_d   = CNT_W'(CAS_LATENCY);
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        dqm_d = 2'b00;
        if (cnt_q == '0) begin
          rdata_d  = sdram_dq_read;
          rvalid_d = 1'b1;
          cnt_d    = CNT_W'(tRP - 1);
          state_d  = RECOVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER, REFRESH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        cnt_d   = '0;
        state_d = INIT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT_WAIT;
      cnt_q      <= '0;
      ref_idx_q  <= 1'b0;
      is_write_q <= 1'b0;
      req_addr_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      ba_q       <= '0;
      dqm_q      <= 2'b11;
      dq_write_q <= '0;
      dq_en_q    <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_idx_q  <= ref_idx_d;
      is_write_q <= is_write_d;
      req_addr_q <= req_addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      ba_q       <= ba_d;
      dqm_q      <= dqm_d;
      dq_write_q <= dq_write_d;
      dq_en_q    <= dq_en_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_addr        = addr_q;
  assign sdram_ba          = ba_q;
  assign sdram_dqm         = dqm_q;
  assign sdram_dq_write    = dq_write_q;
  assign sdram_dq_en       = dq_en_q;
  assign sdram_cke         = 1'b1;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_avalon_sdram_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for avalon_sdram_controller with a behavioural SDRAM device
// model driven from the command pins.
module tb_avalon_sdram_controller;

  localparam int CL      = 2;
  localparam int INIT_N  = 10000;
  localparam int REF_INT = 780;
  localparam int T_RCD   = 2;
  localparam int T_RP    = 2;
  localparam int T_RFC   = 7;
  localparam int T_MRD   = 2;
  localparam int RD_LAT  = 2 + T_RCD + CL;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        clk;
  logic        reset;
  logic        avs_read, avs_write;
  logic [24:0] avs_address;
  logic [1:0]  avs_byteenable;
  logic [15:0] avs_writedata;
  logic        avs_waitrequest, avs_readdatavalid;
  logic [15:0] avs_readdata;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba, sdram_dqm;
  logic        sdram_cke;
  logic [15:0] sdram_dq_read, sdram_dq_write;
  logic        sdram_dq_en;

  avalon_sdram_controller #(
    .CAS_LATENCY(CL), .INIT_CYCLES(INIT_N), .REFRESH_INTERVAL(REF_INT)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avs_readdatavalid(avs_readdatavalid),
    .avs_readdata(avs_readdata),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_dqm(sdram_dqm), .sdram_cke(sdram_cke), .sdram_dq_read(sdram_dq_read),
    .sdram_dq_write(sdram_dq_write), .sdram_dq_en(sdram_dq_en)
  );

  typedef struct {
    logic [15:0] data;
    int          acc;
  } rd_exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] addr;
    int          cyc;
  } cmd_rec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  rd_exp_t     sb[$];
  cmd_rec_t    cmd_log[$];
  logic [15:0] exp_mem[logic [24:0]];
  logic [15:0] dev_mem[logic [24:0]];
  logic [12:0] open_row[4];
  logic [24:0] test_addrs[6];

  logic        log_en = 1'b0;
  logic        ref_watch = 1'b0;
  int          last_ref, max_gap, ref_count;
  int          pulses = 0;
  logic [15:0] last_rdata;
  int          last_lat;
  int          acc_cyc = 0, act_cyc = 0;
  logic [24:0] cur_addr;
  int          rd_cnt = 0;
  logic [15:0] rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_read(input logic [24:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 16'h0000;
  endfunction

  // Device model: decodes pins, tracks open rows, returns read data CL cycles after RD.
  always @(negedge clk) begin
    logic [3:0]  cmd;
    logic [24:0] da;
    logic [15:0] w;
    cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      sdram_dq_read = (rd_cnt == 0) ? rd_data : 16'hDEAD;
    end else begin
      sdram_dq_read = 16'hDEAD;
    end
    if (log_en && cmd != C_NOP) cmd_log.push_back('{cmd, sdram_addr, cyc});
    case (cmd)
      C_ACT: begin
        open_row[sdram_ba] = sdram_addr;
        act_cyc = cyc;
        vectors++;
        if (cyc !== acc_cyc + 1) begin
          miscompares++;
          $display("[TB] FAIL act_timing: ACT at cycle %0d, required %0d", cyc, acc_cyc + 1);
        end
      end
      C_RD, C_WR: begin
        da = {sdram_ba, open_row[sdram_ba], sdram_addr[9:0]};
        vectors++;
        if (da !== cur_addr || sdram_addr[10] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL rw_address: got %h a10=%b, required %h a10=1", da, sdram_addr[10], cur_addr);
        end
        vectors++;
        if (cyc !== act_cyc + T_RCD) begin
          miscompares++;
          $display("[TB] FAIL rw_timing: RD/WR at cycle %0d, required %0d", cyc, act_cyc + T_RCD);
        end
        if (cmd == C_WR) begin
          vectors++;
          if (sdram_dq_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_dq_en: got %b, required 1", sdram_dq_en);
          end
          w = dev_mem.exists(da) ? dev_mem[da] : 16'h0000;
          if (!sdram_dqm[0]) w[7:0]  = sdram_dq_write[7:0];
          if (!sdram_dqm[1]) w[15:8] = sdram_dq_write[15:8];
          dev_mem[da] = w;
        end else begin
          rd_data = dev_mem.exists(da) ? dev_mem[da] : 16'h0000;
          rd_cnt  = CL;
        end
      end
      C_REF: begin
        if (ref_watch) begin
          if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
          last_ref = cyc;
          ref_count++;
        end
      end
      default: ;
    endcase
  end

  // Scoreboard consumer for read data.
  always @(negedge clk) begin
    rd_exp_t e;
    if (avs_readdatavalid === 1'b1) begin
      pulses++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_rvalid: pulse at cycle %0d with data %h, required none", cyc, avs_readdata);
      end else begin
        e = sb.pop_front();
        last_rdata = avs_readdata;
        last_lat   = cyc - e.acc;
        if (avs_readdata !== e.data) begin
          miscompares++;
          $display("[TB] FAIL read_data: got %h, required %h", avs_readdata, e.data);
        end
        vectors++;
        if (cyc - e.acc !== RD_LAT) begin
          miscompares++;
          $display("[TB] FAIL read_latency: got %0d, required %0d", cyc - e.acc, RD_LAT);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Caller must be at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic rd, input logic wr, input logic [24:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    int guard;
    logic [15:0] m;
    avs_read = rd; avs_write = wr; avs_address = a;
    avs_writedata = d; avs_byteenable = be;
    guard = 0;
    while (avs_waitrequest === 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: waitrequest=%b after %0d cycles, required 0", avs_waitrequest, guard);
    end else begin
      acc_cyc  = cyc;
      cur_addr = a;
      if (wr) begin
        m = {{8{be[1]}}, {8{be[0]}}};
        exp_mem[a] = (exp_read(a) & ~m) | (d & m);
      end else begin
        sb.push_back('{exp_read(a), cyc});
      end
    end
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d reads outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int rel;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== C_NOP || sdram_cke !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_cmd: cmd=%b cke=%b, required 0111 1",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_cke);
    end
    vectors++;
    if (sdram_addr !== 13'h0 || sdram_ba !== 2'b00 || sdram_dqm !== 2'b11 || sdram_dq_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pins: addr=%h ba=%b dqm=%b dq_en=%b, required 0 00 11 0",
               sdram_addr, sdram_ba, sdram_dqm, sdram_dq_en);
    end
    vectors++;
    if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0 || avs_readdata !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_avalon: wait=%b rvalid=%b rdata=%h, required 1 0 0000",
               avs_waitrequest, avs_readdatavalid, avs_readdata);
    end
    cmd_log.delete();
    log_en = 1'b1;
    rel = cyc;
    reset = 1'b0;
    while (avs_waitrequest === 1'b1 && (cyc - rel) < INIT_N + 30) @(negedge clk);
    log_en = 1'b0;
    vectors++;
    if (avs_waitrequest !== 1'b0 || (cyc - rel) < INIT_N) begin
      miscompares++;
      $display("[TB] FAIL init_done: wait=%b after %0d cycles, required 0 within [%0d,%0d]",
               avs_waitrequest, cyc - rel, INIT_N, INIT_N + 30);
    end
    vectors++;
    if (cmd_log.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL init_cmd_count: got %0d commands, required 4", cmd_log.size());
    end else begin
      vectors++;
      if (cmd_log[0].cmd !== C_PRE || cmd_log[0].addr[10] !== 1'b1 || cmd_log[0].cyc !== rel + INIT_N) begin
        miscompares++;
        $display("[TB] FAIL init_pre: cmd=%b a10=%b cyc=%0d, required 0010 1 %0d",
                 cmd_log[0].cmd, cmd_log[0].addr[10], cmd_log[0].cyc, rel + INIT_N);
      end
      vectors++;
      if (cmd_log[1].cmd !== C_REF || cmd_log[1].cyc !== cmd_log[0].cyc + T_RP) begin
        miscompares++;
        $display("[TB] FAIL init_ref1: cmd=%b cyc=%0d, required 0001 %0d",
                 cmd_log[1].cmd, cmd_log[1].cyc, cmd_log[0].cyc + T_RP);
      end
      vectors++;
      if (cmd_log[2].cmd !== C_REF || cmd_log[2].cyc !== cmd_log[1].cyc + T_RFC) begin
        miscompares++;
        $display("[TB] FAIL init_ref2: cmd=%b cyc=%0d, required 0001 %0d",
                 cmd_log[2].cmd, cmd_log[2].cyc, cmd_log[1].cyc + T_RFC);
      end
      vectors++;
      if (cmd_log[3].cmd !== C_MRS || cmd_log[3].addr !== 13'h020 || cmd_log[3].cyc !== cmd_log[2].cyc + T_RFC) begin
        miscompares++;
        $display("[TB] FAIL init_mrs: cmd=%b addr=%h cyc=%0d, required 0000 020 %0d",
                 cmd_log[3].cmd, cmd_log[3].addr, cmd_log[3].cyc, cmd_log[2].cyc + T_RFC);
      end
      vectors++;
      if (cyc !== cmd_log[3].cyc + T_MRD) begin
        miscompares++;
        $display("[TB] FAIL init_idle: waitrequest fell at %0d, required %0d", cyc, cmd_log[3].cyc + T_MRD);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    issue(1'b0, 1'b1, 25'h0001234, 16'hA5C3, 2'b11);
    issue(1'b1, 1'b0, 25'h0001234, 16'h0000, 2'b11);
    drain();
    vectors++;
    if (last_rdata !== 16'hA5C3 || last_lat !== 6) begin
      miscompares++;
      $display("[TB] FAIL write_read: data=%h latency=%0d, required A5C3 6", last_rdata, last_lat);
    end
  endtask

  task automatic test_byteenable();
    @(negedge clk);
    issue(1'b0, 1'b1, 25'h0ABCDEF, 16'hFFFF, 2'b11);
    issue(1'b0, 1'b1, 25'h0ABCDEF, 16'h1200, 2'b10);
    issue(1'b1, 1'b0, 25'h0ABCDEF, 16'h0000, 2'b11);
    drain();
    vectors++;
    if (last_rdata !== 16'h12FF) begin
      miscompares++;
      $display("[TB] FAIL byteenable: data=%h, required 12FF", last_rdata);
    end
  endtask

  task automatic test_banks_extremes();
    test_addrs[0] = 25'h0000000;
    test_addrs[1] = 25'h1FFFFFF;
    for (int b = 0; b < 4; b++)
      test_addrs[b + 2] = {2'(b), 13'h0ABC ^ 13'(b * 977), 10'h155 ^ 10'(b * 123)};
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      issue(1'b0, 1'b1, test_addrs[i], 16'h3C00 ^ 16'(i * 16'h1111) ^ test_addrs[i][15:0], 2'b11);
    for (int i = 0; i < 6; i++)
      issue(1'b1, 1'b0, test_addrs[i], 16'h0000, 2'b11);
    drain();
  endtask

  task automatic test_collision();
    int p0;
    @(negedge clk);
    issue(1'b0, 1'b1, 25'h1234567, 16'h1111, 2'b11);
    p0 = pulses;
    issue(1'b1, 1'b1, 25'h1234567, 16'h5A5A, 2'b11);
    repeat (12) @(negedge clk);
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("[TB] FAIL collision_pulse: %0d pulses, required 0", pulses - p0);
    end
    issue(1'b1, 1'b0, 25'h1234567, 16'h0000, 2'b11);
    drain();
    vectors++;
    if (last_rdata !== 16'h5A5A) begin
      miscompares++;
      $display("[TB] FAIL collision_data: data=%h, required 5A5A", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int start, i;
    @(negedge clk);
    start = cyc;
    last_ref = cyc; max_gap = 0; ref_count = 0;
    ref_watch = 1'b1;
    i = 0;
    while (cyc - start < 2100) begin
      issue(1'b1, 1'b0, test_addrs[i % 6], 16'h0000, 2'b11);
      i++;
    end
    drain();
    ref_watch = 1'b0;
    if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
    vectors++;
    if (max_gap > REF_INT + 20 || ref_count < 2) begin
      miscompares++;
      $display("[TB] FAIL refresh_gap: max gap %0d with %0d REFs, required <= %0d with >= 2",
               max_gap, ref_count, REF_INT + 20);
    end
  endtask

  task automatic test_reset_mid_read();
    int p0, rel;
    @(negedge clk);
    issue(1'b0, 1'b1, 25'h0F0F0F0, 16'hBEEF, 2'b11);
    issue(1'b1, 1'b0, 25'h0F0F0F0, 16'h0000, 2'b11);
    sb.delete();
    p0 = pulses;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmd_log.delete();
    log_en = 1'b1;
    rel = cyc;
    reset = 1'b0;
    while (avs_waitrequest === 1'b1 && (cyc - rel) < INIT_N + 30) @(negedge clk);
    log_en = 1'b0;
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("[TB] FAIL abort_pulse: %0d pulses, required 0", pulses - p0);
    end
    vectors++;
    if (avs_waitrequest !== 1'b0 || (cyc - rel) < INIT_N) begin
      miscompares++;
      $display("[TB] FAIL reinit_done: wait=%b after %0d cycles, required 0 within [%0d,%0d]",
               avs_waitrequest, cyc - rel, INIT_N, INIT_N + 30);
    end
    vectors++;
    if (cmd_log.size() != 4 || cmd_log[0].cmd !== C_PRE || cmd_log[3].cmd !== C_MRS) begin
      miscompares++;
      $display("[TB] FAIL reinit_seq: %0d commands, required PRE,REF,REF,MRS", cmd_log.size());
    end
    issue(1'b0, 1'b1, 25'h1555AAA, 16'h7E81, 2'b11);
    issue(1'b1, 1'b0, 25'h1555AAA, 16'h0000, 2'b11);
    drain();
    vectors++;
    if (last_rdata !== 16'h7E81) begin
      miscompares++;
      $display("[TB] FAIL post_reset_read: data=%h, required 7E81", last_rdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    avs_read = 1'b0; avs_write = 1'b0;
    avs_address = '0; avs_byteenable = 2'b11; avs_writedata = '0;
    sdram_dq_read = 16'hDEAD;
    for (int b = 0; b < 4; b++) open_row[b] = '0;
    test_reset();
    test_write_read();
    test_byteenable();
    test_banks_extremes();
    test_collision();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
